// File: rtl/reg_sort_ctrl.sv
// In-place bubble sort of a 16x8 register file with early exit on a swap-free pass.
// Compare costs 3 cycles (5 on a swap); Start is only taken in IDLE; no backpressure.
module reg_sort_ctrl #(
  parameter bit DESCENDING = 1'b0
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  output logic [3:0] R_Addr,
  output logic       R_en,
  input  logic [7:0] R_Data,
  output logic [3:0] W_Addr,
  output logic       W_en,
  output logic [7:0] W_Data,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Swap_Count
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CMP, WR_A, WR_B, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] i, i_nxt, j, j_nxt;
  logic [7:0] a, a_nxt, b, b_nxt, cnt_nxt;
  logic       flag, flag_nxt;
  logic       swap_req, pass_end, adv, adv_flag;

  assign swap_req = DESCENDING ? (a < b) : (a > b);
  assign pass_end = (j == (4'd14 - i));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      i          <= 4'd0;
      j          <= 4'd0;
      a          <= 8'd0;
      b          <= 8'd0;
      flag       <= 1'b0;
      Swap_Count <= 8'd0;
    end else begin
      state      <= state_nxt;
      i          <= i_nxt;
      j          <= j_nxt;
      a          <= a_nxt;
      b          <= b_nxt;
      flag       <= flag_nxt;
      Swap_Count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    a_nxt     = a;
    b_nxt     = b;
    flag_nxt  = flag;
    cnt_nxt   = Swap_Count;
    R_Addr    = 4'd0;
    R_en      = 1'b0;
    W_Addr    = 4'd0;
    W_en      = 1'b0;
    W_Data    = 8'd0;
    Done      = 1'b0;
    adv       = 1'b0;
    adv_flag  = flag;
    case (state)
      IDLE: begin
        if (Start) begin
          i_nxt     = 4'd0;
          j_nxt     = 4'd0;
          cnt_nxt   = 8'd0;
          flag_nxt  = 1'b0;
          state_nxt = RD_A;
        end
      end
      RD_A: begin
        R_en      = 1'b1;
        R_Addr    = j;
        a_nxt     = R_Data;
        state_nxt = RD_B;
      end
      RD_B: begin
        R_en      = 1'b1;
        R_Addr    = j + 4'd1;
        b_nxt     = R_Data;
        state_nxt = CMP;
      end
      CMP: begin
        if (swap_req) state_nxt = WR_A;
        else          adv       = 1'b1;
      end
      WR_A: begin
        W_en      = 1'b1;
        W_Addr    = j;
        W_Data    = b;
        state_nxt = WR_B;
      end
      WR_B: begin
        W_en     = 1'b1;
        W_Addr   = j + 4'd1;
        W_Data   = a;
        cnt_nxt  = Swap_Count + 8'd1;
        flag_nxt = 1'b1;
        adv      = 1'b1;
        adv_flag = 1'b1;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A swap in WR_B counts toward this pass even though the flag register updates later.
    if (adv) begin
      if (!pass_end) begin
        j_nxt     = j + 4'd1;
        state_nxt = RD_A;
      end else if (!adv_flag || (i == 4'd14)) begin
        state_nxt = DONE;
      end else begin
        i_nxt     = i + 4'd1;
        j_nxt     = 4'd0;
        flag_nxt  = 1'b0;
        state_nxt = RD_A;
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_reg_sort_ctrl.sv
// Bench for reg_sort_ctrl: table of sort cases (ascending and descending instances) scored
// against queued expectations, plus held-Start restart and reset-in-WR_A sequences.
module tb_reg_sort_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst;
  logic       start0, start1;
  logic [3:0] raddr0, waddr0, raddr1, waddr1;
  logic       ren0, wen0, ren1, wen1;
  logic [7:0] rdata0, wdata0, rdata1, wdata1;
  logic       busy0, done0, busy1, done1;
  logic [7:0] cnt0, cnt1;

  logic [7:0]   mem0 [16];
  logic [7:0]   mem1 [16];
  logic         load0, load1;
  logic [127:0] load_img;
  int           wr_cnt0 = 0, wr_cnt1 = 0, overlap = 0;
  int           errors = 0, checks = 0;

  logic sel;
  logic done_s, busy_s;
  logic [7:0] cnt_s;
  assign done_s = sel ? done1 : done0;
  assign busy_s = sel ? busy1 : busy0;
  assign cnt_s  = sel ? cnt1  : cnt0;

  localparam logic [127:0] ASC  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] DESC = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] MIX  = 128'h33463A3F3236261F31283B3739443530;
  localparam logic [127:0] MIXS = 128'h46443F3B3A393736353332313028261F;
  localparam logic [127:0] ALLA = {16{8'hAA}};

  reg_sort_ctrl #(.DESCENDING(1'b0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Start(start0), .R_Addr(raddr0), .R_en(ren0), .R_Data(rdata0),
    .W_Addr(waddr0), .W_en(wen0), .W_Data(wdata0), .Busy(busy0), .Done(done0), .Swap_Count(cnt0));

  reg_sort_ctrl #(.DESCENDING(1'b1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Start(start1), .R_Addr(raddr1), .R_en(ren1), .R_Data(rdata1),
    .W_Addr(waddr1), .W_en(wen1), .W_Data(wdata1), .Busy(busy1), .Done(done1), .Swap_Count(cnt1));

  // Register-file models: combinational read, write at the rising edge.
  assign rdata0 = ren0 ? mem0[raddr0] : 8'h00;
  assign rdata1 = ren1 ? mem1[raddr1] : 8'h00;

  always @(posedge Clk) begin
    if (load0) for (int k = 0; k < 16; k++) mem0[k] <= load_img[8*k +: 8];
    else if (wen0) mem0[waddr0] <= wdata0;
    if (load1) for (int k = 0; k < 16; k++) mem1[k] <= load_img[8*k +: 8];
    else if (wen1) mem1[waddr1] <= wdata1;
    if (wen0) wr_cnt0 <= wr_cnt0 + 1;
    if (wen1) wr_cnt1 <= wr_cnt1 + 1;
    if ((ren0 && wen0) || (ren1 && wen1)) overlap <= overlap + 1;
  end

  typedef struct {
    logic [127:0] init;
    logic         desc;
    logic [127:0] fin;
    int           swaps;
    int           lat;
    logic         poke;
  } vec_t;

  typedef struct {
    logic [127:0] fin;
    int           swaps;
    int           lat;
  } exp_t;

  vec_t tbl [7];
  exp_t sbq [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference bubble sort: result, swap count and Done latency from the per-compare cycle costs.
  function automatic void model(input logic [127:0] init, input logic desc,
                                output logic [127:0] fin, output int swaps, output int lat);
    logic [7:0] v [16];
    logic [7:0] t;
    logic sw;
    int cyc;
    cyc = 0;
    swaps = 0;
    for (int k = 0; k < 16; k++) v[k] = init[8*k +: 8];
    for (int p = 0; p < 15; p++) begin
      sw = 1'b0;
      for (int q = 0; q < 15 - p; q++) begin
        cyc += 3;
        if (desc ? (v[q] < v[q+1]) : (v[q] > v[q+1])) begin
          t = v[q]; v[q] = v[q+1]; v[q+1] = t;
          swaps++;
          sw = 1'b1;
          cyc += 2;
        end
      end
      if (!sw) break;
    end
    lat = cyc + 1;
    for (int k = 0; k < 16; k++) fin[8*k +: 8] = v[k];
  endfunction

  function automatic logic [127:0] img(input logic s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = s ? mem1[k] : mem0[k];
    return r;
  endfunction

  task automatic load(input logic s, input logic [127:0] v);
    @(negedge Clk);
    load_img = v;
    if (s) load1 = 1'b1; else load0 = 1'b1;
    @(negedge Clk);
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  task automatic drive_start(input logic s, input logic v);
    if (s) start1 = v; else start0 = v;
  endtask

  task automatic run(input logic s, input logic poke, input logic [127:0] init,
                     input exp_t e, input string tag);
    int   w0, lat;
    exp_t g;
    load(s, init);
    sel = s;
    sbq.push_back(e);
    w0 = s ? wr_cnt1 : wr_cnt0;
    lat = 0;
    @(negedge Clk);
    drive_start(s, 1'b1);
    @(posedge Clk);
    for (int c = 1; c <= 2000; c++) begin
      @(negedge Clk);
      drive_start(s, 1'b0);
      if (c == 10) check({tag, "_busy"}, busy_s, 1'b1);
      if (poke && c == 20) drive_start(s, 1'b1);
      if (done_s) begin
        lat = c;
        break;
      end
    end
    g = sbq.pop_front();
    check({tag, "_lat"}, lat, g.lat);
    check({tag, "_data"}, img(s), g.fin);
    check({tag, "_swaps"}, cnt_s, g.swaps);
    check({tag, "_writes"}, (s ? wr_cnt1 : wr_cnt0) - w0, 2 * g.swaps);
    @(negedge Clk);
    check({tag, "_done_pulse"}, {busy_s, done_s}, 2'b00);
    @(negedge Clk);
    check({tag, "_cnt_hold"}, cnt_s, g.swaps);
  endtask

  initial begin
    logic [127:0] mf;
    int           ms, ml, lat;
    exp_t         e;
    logic [127:0] r;

    Rst = 1'b0; start0 = 1'b0; start1 = 1'b0; load0 = 1'b0; load1 = 1'b0;
    load_img = '0; sel = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_busy_done", {busy0, done0, busy1, done1}, 4'h0);
    check("rst_rd", {ren0, raddr0, ren1, raddr1}, 10'h0);
    check("rst_wr", {wen0, waddr0, wdata0, wen1, waddr1, wdata1}, 26'h0);
    check("rst_cnt", {cnt0, cnt1}, 16'h0);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_wait", {busy0, busy1}, 2'b00);

    tbl[0] = '{ASC,  1'b0, ASC,  0,   46,  1'b0};
    tbl[1] = '{DESC, 1'b0, ASC,  120, 601, 1'b0};
    tbl[2] = '{MIX,  1'b0, MIXS, -1,  -1,  1'b0};
    tbl[3] = '{ALLA, 1'b0, ALLA, 0,   46,  1'b0};
    tbl[4] = '{ASC,  1'b1, DESC, 120, 601, 1'b1};
    for (int n = 5; n < 7; n++) begin
      for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'($urandom_range(0, 255));
      tbl[n].init = r;
      tbl[n].desc = (n == 5);
      model(r, tbl[n].desc, tbl[n].fin, ms, ml);
      tbl[n].swaps = ms;
      tbl[n].lat = ml;
      tbl[n].poke = 1'b0;
    end

    for (int n = 0; n < 7; n++) begin
      model(tbl[n].init, tbl[n].desc, mf, ms, ml);
      e.fin   = tbl[n].fin;
      e.swaps = (tbl[n].swaps < 0) ? ms : tbl[n].swaps;
      e.lat   = (tbl[n].lat < 0) ? ml : tbl[n].lat;
      run(tbl[n].desc, tbl[n].poke, tbl[n].init, e, $sformatf("vec%0d", n));
    end

    // Start held high: the cycle after DONE is IDLE, which accepts the next sort.
    load(1'b0, DESC);
    sel = 1'b0;
    lat = 0;
    @(negedge Clk);
    start0 = 1'b1;
    @(posedge Clk);
    for (int c = 1; c <= 2000; c++) begin
      @(negedge Clk);
      if (done0) begin lat = c; break; end
    end
    check("hold_lat1", lat, 601);
    @(negedge Clk);
    check("hold_idle", {busy0, cnt0}, {1'b0, 8'd120});
    @(negedge Clk);
    check("hold_restart", {busy0, cnt0}, {1'b1, 8'd0});
    start0 = 1'b0;
    lat = 0;
    for (int c = 2; c <= 2000; c++) begin
      @(negedge Clk);
      if (done0) begin lat = c; break; end
    end
    check("hold_lat2", lat, 46);
    check("hold_result", {img(1'b0), cnt0}, {ASC, 8'd0});

    // Reset on the first WR_A cycle: everything drops at once and the write is lost.
    load(1'b0, DESC);
    @(negedge Clk);
    start0 = 1'b1;
    @(negedge Clk);
    start0 = 1'b0;
    for (int c = 0; c < 50 && !wen0; c++) @(negedge Clk);
    check("wra_seen", {wen0, waddr0, wdata0}, {1'b1, 4'd0, 8'h0E});
    Rst = 1'b0;
    #1;
    check("wra_rst_out", {busy0, done0, ren0, raddr0, wen0, waddr0, wdata0, cnt0}, 28'h0);
    @(posedge Clk);
    #1;
    check("wra_no_write", img(1'b0), DESC);
    @(negedge Clk);
    Rst = 1'b1;
    e.fin = ASC; e.swaps = 120; e.lat = 601;
    run(1'b0, 1'b0, DESC, e, "after_rst");

    check("rw_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_sort_ctrl.md
REG_SORT_CTRL -- requirements
Module: reg_sort_ctrl

Interface
REQ-001 SHALL have parameter DESCENDING, default 0: 0 sorts ascending, 1 sorts descending.
REQ-002 SHALL have port Clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port Rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port Start, input, 1: request to sort the 16x8 register file; sampled only in IDLE.
REQ-005 SHALL have port R_Addr, output, 4: register-file read address.
REQ-006 SHALL have port R_en, output, 1: register-file read enable.
REQ-007 SHALL have port R_Data, input, 8: register-file read data, combinational from R_Addr/R_en, valid in the same cycle.
REQ-008 SHALL have port W_Addr, output, 4: register-file write address.
REQ-009 SHALL have port W_en, output, 1: register-file write enable; the write takes effect at the next rising edge.
REQ-010 SHALL have port W_Data, output, 8: register-file write data.
REQ-011 SHALL have port Busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port Done, output, 1: one-cycle pulse on completion.
REQ-013 SHALL have port Swap_Count, output, 8: swaps performed by the current or last sort.

Function
REQ-014 SHALL implement bubble sort over entries 0..15: outer pass index i runs 0..14; inner compare index j runs 0..14-i, comparing entries j and j+1.
REQ-015 SHALL use FSM states IDLE, RD_A, RD_B, CMP, WR_A, WR_B and DONE.
REQ-016 IDLE: on Start=1, SHALL set i=0, j=0, Swap_Count=0 and the pass-swap flag to 0, then go to RD_A.
REQ-017 RD_A: SHALL drive R_en=1 and R_Addr=j, latch R_Data into A, then go to RD_B.
REQ-018 RD_B: SHALL drive R_en=1 and R_Addr=j+1, latch R_Data into B, then go to CMP.
REQ-019 CMP: SHALL require a swap when A>B (DESCENDING=0) or A<B (DESCENDING=1); swap -> WR_A, else advance.
REQ-020 Equal values SHALL never swap, so the sort is stable and produces no write.
REQ-021 WR_A: SHALL drive W_en=1, W_Addr=j, W_Data=B, then go to WR_B.
REQ-022 WR_B: SHALL drive W_en=1, W_Addr=j+1, W_Data=A, increment Swap_Count, set the pass-swap flag, then advance.
REQ-023 Advance when j<14-i: SHALL set j=j+1 and go to RD_A.
REQ-024 Advance when j=14-i (end of pass): if the pass-swap flag is 0 or i=14, SHALL go to DONE; else set i=i+1, j=0, clear the flag, and go to RD_A.
REQ-025 Timing: a non-swapping compare SHALL take 3 cycles and a swapping compare 5 cycles; there are no idle cycles between compares.
REQ-026 DONE: SHALL assert Done=1 for exactly one cycle, then go to IDLE; Swap_Count SHALL hold until the next accepted Start.
REQ-027 Start SHALL be ignored while Busy=1.
REQ-028 Start=1 held continuously SHALL restart a sort on the cycle after DONE (IDLE accepts it).
REQ-029 R_en SHALL be 0 outside RD_A/RD_B, and R_Addr SHALL be 0 there.
REQ-030 W_en SHALL be 0 outside WR_A/WR_B, and W_Addr and W_Data SHALL be 0 there.
REQ-031 R_en and W_en SHALL never be high in the same cycle.

Reset
REQ-032 Rst=0 SHALL immediately force state IDLE and all of i, j, A, B, the pass-swap flag, Swap_Count, R_Addr, R_en, W_Addr, W_en, W_Data, Busy and Done to 0.
REQ-033 Reset mid-sort SHALL abort without completing any pending write; register-file contents are left as last written.
REQ-034 After Rst returns to 1, the block SHALL wait in IDLE for a new Start.

Verification
REQ-035 Contents 0..15 ascending, DESCENDING=0, Start pulse -> Done 46 cycles after the accepting edge, Swap_Count=0, W_en never high.
REQ-036 Contents 15..0, DESCENDING=0 -> final contents 0..15, Swap_Count=120, Done 601 cycles after the accepting edge.
REQ-037 Contents 48,53,68,57,55,59,40,49,31,38,54,50,63,58,70,51 -> final contents 31,38,40,48,49,50,51,53,54,55,57,58,59,63,68,70; Swap_Count equals the bench model's inversion count.
REQ-038 All entries 8'hAA -> one pass, Swap_Count=0, Done 46 cycles after the accepting edge.
REQ-039 DESCENDING=1, contents 0..15 -> final contents 15..0, Swap_Count=120; a second Start pulse while Busy changes nothing.
REQ-040 Rst=0 asserted in a WR_A cycle -> all outputs 0 within the same cycle, Busy=0; a new Start then completes the sort correctly.
